// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer datapath.
//   - Opcode encodings understood by the combinational ALU (ula) and by
//     the sequencer (ula_seq), including the sequencer-only MUL opcode.
//   - OP_IDLE_SEL: ALU select driven while no operation is in flight; the
//     ALU decodes it as "output 0".
//   - state_t: sequencer FSM states.
package ula_pkg;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_AND      = 4'b0010;
  localparam logic [3:0] OP_OR       = 4'b0011;
  localparam logic [3:0] OP_NOT      = 4'b0100;
  localparam logic [3:0] OP_MUL      = 4'b0101;
  localparam logic [3:0] OP_IDLE_SEL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Opcodes 0000..0101 are legal; everything above MUL is illegal.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/ula.sv
// Combinational 8-bit ALU.
// Ports:
//   a, b : operands
//   s    : select (ADD, SUB, AND, OR, NOT A); any other select gives 0
//   out  : result, modulo 2^8
module ula
  import ula_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    case (s)
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_NOT:  out = ~a;
      default: out = 8'h00;
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// Sequencing front-end for the combinational ALU (ula).
// Accepts one operation per valid/ready handshake, drives the ALU operand
// and select lines, registers the result with zero/negative/error flags and
// keeps an 8-bit accumulator. MUL is a shift-add multiply built from
// N_MUL_STEPS iterated ALU ADDs.
// Ports:
//   clk, rst_n                      : clock (rising edge), async active-low reset
//   req_valid/req_ready             : request handshake
//   req_op, req_a, req_b            : opcode and operands
//   req_use_acc                     : take operand A from the accumulator
//   alu_a, alu_b, alu_s             : to the ALU
//   alu_out                         : from the ALU
//   rsp_valid/rsp_ready             : response handshake
//   rsp_data, rsp_zero, rsp_neg,
//   rsp_err                         : result and flags
//   acc                             : accumulator
module ula_seq
  import ula_pkg::*;
#(
  parameter int N_MUL_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_neg,
  output logic       rsp_err,
  output logic [7:0] acc
);

  localparam logic [2:0] LAST_STEP = 3'(N_MUL_STEPS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [7:0] r_a;        // operand A, also the MUL multiplicand
  logic [7:0] r_b;        // operand B, also the MUL multiplier
  logic [7:0] r_p;        // MUL partial product
  logic [2:0] r_step;
  logic [7:0] r_rsp_data;
  logic       r_zero;
  logic       r_neg;
  logic       r_err;
  logic [7:0] r_acc;

  logic       w_last_step;
  logic [7:0] w_mul_p;
  logic       w_legal;

  assign w_last_step = (r_step == LAST_STEP);
  // The ALU always computes P + (M << i); keep it only when multiplier bit i is set.
  assign w_mul_p     = r_b[r_step] ? alu_out : r_p;
  assign w_legal     = op_is_legal(r_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_s     = OP_IDLE_SEL;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (req_op == OP_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        alu_a  = r_a;
        alu_b  = r_b;
        alu_s  = r_op;
        w_next = RESP;
      end
      MUL: begin
        alu_a = r_p;
        alu_b = r_a << r_step;
        alu_s = OP_ADD;
        if (w_last_step) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= 4'h0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_p        <= 8'h00;
      r_step     <= 3'd0;
      r_rsp_data <= 8'h00;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
      r_acc      <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op   <= req_op;
            r_a    <= req_use_acc ? r_acc : req_a;
            r_b    <= req_b;
            r_p    <= 8'h00;
            r_step <= 3'd0;
          end
        end
        EXEC: begin
          r_err <= ~w_legal;
          if (w_legal) begin
            r_rsp_data <= alu_out;
            r_zero     <= (alu_out == 8'h00);
            r_neg      <= alu_out[7];
            r_acc      <= alu_out;
          end else begin
            // Illegal op: zero result, accumulator left untouched.
            r_rsp_data <= 8'h00;
            r_zero     <= 1'b1;
            r_neg      <= 1'b0;
          end
        end
        MUL: begin
          r_p    <= w_mul_p;
          r_step <= r_step + 3'd1;
          if (w_last_step) begin
            r_rsp_data <= w_mul_p;
            r_zero     <= (w_mul_p == 8'h00);
            r_neg      <= w_mul_p[7];
            r_err      <= 1'b0;
            r_acc      <= w_mul_p;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_zero;
  assign rsp_neg  = r_neg;
  assign rsp_err  = r_err;
  assign acc      = r_acc;

endmodule

// File: tb/tb_ula_seq.sv
module tb_ula_seq;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_s;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_neg;
  logic       rsp_err;
  logic [7:0] acc;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_acc = 8'h00;

  always #5 clk = ~clk;

  ula_seq #(.N_MUL_STEPS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .acc(acc)
  );

  ula u_ula (.a(alu_a), .b(alu_b), .s(alu_s), .out(alu_out));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the operation means, in plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic err);
    int unsigned full;
    err = 1'b0;
    case (op)
      4'd0: full = int'(a) + int'(b);
      4'd1: full = int'(a) + 256 - int'(b);
      4'd2: full = int'(a & b);
      4'd3: full = int'(a | b);
      4'd4: full = 255 - int'(a);
      4'd5: full = int'(a) * int'(b);
      default: begin full = 0; err = 1'b1; end
    endcase
    res = 8'(full % 256);
  endtask

  // One transaction; hold > 0 keeps rsp_ready low that many cycles while a
  // competing request is presented.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ua, input int hold);
    logic [7:0] ea, er;
    logic       ee;
    int         lat;
    logic       seen;
    ea = ua ? exp_acc : a;
    model(op, ea, b, er, ee);
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);
    check("idle_rsp_valid", rsp_valid, 0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_acc = ua;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_a = 8'($urandom); req_b = 8'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    check("latency", lat, (op == 4'd5) ? 9 : 2);
    if (!seen) return;
    if (!ee) exp_acc = er;
    check("rsp_data", rsp_data, er);
    check("rsp_zero", rsp_zero, (er == 8'h00));
    check("rsp_neg", rsp_neg, er[7]);
    check("rsp_err", rsp_err, ee);
    check("acc", acc, exp_acc);
    if (hold > 0) begin
      req_valid = 1'b1; req_op = 4'd0; req_a = 8'h11; req_b = 8'h22; req_use_acc = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_data", rsp_data, er);
        check("bp_req_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
  endtask

  // Start an op, assert reset mid-cycle after 'extra' further edges, check
  // that everything clears before the next edge and no response appears.
  task automatic reset_during(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int extra);
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_use_acc = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < extra; i++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", acc, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_alu_s", alu_s, 4'hF);
    check("arst_rsp_data", rsp_data, 0);
    exp_acc = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("arst_no_rsp", seen, 0);
    check("arst_acc_after", acc, 0);
  endtask

  initial begin
    logic [3:0] rop;
    int r;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = 8'h00; req_b = 8'h00;
    req_use_acc = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_alu_s", alu_s, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_alu_a", alu_a, 0);
    check("post_rst_alu_b", alu_b, 0);
    check("post_rst_alu_s", alu_s, 4'hF);
    check("post_rst_data", {rsp_data, rsp_zero, rsp_neg, rsp_err}, 0);

    do_op(4'd0, 8'h3C, 8'h14, 1'b0, 0);   // 0x50
    check("add_acc", acc, 8'h50);
    do_op(4'd1, 8'h00, 8'h50, 1'b1, 0);   // acc - 0x50 = 0
    check("sub_zero", rsp_zero, 1);
    do_op(4'd1, 8'h00, 8'h01, 1'b1, 0);   // 0 - 1 = 0xFF
    check("sub_neg", rsp_neg, 1);
    do_op(4'd4, 8'h0F, 8'h00, 1'b0, 0);   // 0xF0
    check("not_data", rsp_data, 8'hF0);
    do_op(4'd5, 8'h0D, 8'h0B, 1'b0, 0);   // 0x8F
    check("mul_data", rsp_data, 8'h8F);
    do_op(4'd5, 8'h10, 8'h10, 1'b0, 0);   // 0x00
    check("mul_zero", rsp_zero, 1);
    do_op(4'd5, 8'hFF, 8'h01, 1'b0, 0);   // 0xFF
    do_op(4'd2, 8'hF0, 8'h3C, 1'b0, 5);   // 0x30 under backpressure
    check("and_acc", acc, 8'h30);
    do_op(4'b1001, 8'h12, 8'h34, 1'b0, 0);
    check("illegal_acc", acc, 8'h30);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      rop = (r < 6) ? 4'(r) : 4'($urandom_range(6, 15));
      do_op(rop, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0 ? 2 : 0);
    end

    reset_during(4'd0, 8'h21, 8'h43, 0);   // reset while in EXEC
    do_op(4'd0, 8'h01, 8'h02, 1'b0, 0);
    reset_during(4'd5, 8'h0D, 8'h0B, 4);   // reset during MUL step 4

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
